// File: rtl/amb_hakemi.sv
// amb_hakemi
// Arbiter that lets two requesters share one external combinational ALU.
// At most one operation is issued per cycle. A requester may issue when it
// has an operation and its response slot is empty or being drained this
// cycle. When both may issue, the round-robin pointer picks the winner.
// The ALU result is captured into the winner's response slot on the next
// edge, so the result is visible exactly one cycle after acceptance.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   istekN_gecerli_i / _hazir_o    request handshake of requester N (0/1)
//   istekN_kontrol_i               opcode of requester N
//   istekN_deger1_i / _deger2_i    operands of requester N
//   yanitN_gecerli_o / _hazir_i    response handshake of requester N
//   yanitN_sonuc_o                 response data of requester N
//   amb_kontrol_o, amb_deger1_o/2  opcode/operands driven to the shared ALU
//   amb_sonuc_i                    combinational result from the shared ALU
module amb_hakemi #(
    parameter int VERI_BIT    = 32,
    parameter int KONTROL_BIT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   istek0_gecerli_i,
    output logic                   istek0_hazir_o,
    input  logic [KONTROL_BIT-1:0] istek0_kontrol_i,
    input  logic [VERI_BIT-1:0]    istek0_deger1_i,
    input  logic [VERI_BIT-1:0]    istek0_deger2_i,
    output logic                   yanit0_gecerli_o,
    input  logic                   yanit0_hazir_i,
    output logic [VERI_BIT-1:0]    yanit0_sonuc_o,

    input  logic                   istek1_gecerli_i,
    output logic                   istek1_hazir_o,
    input  logic [KONTROL_BIT-1:0] istek1_kontrol_i,
    input  logic [VERI_BIT-1:0]    istek1_deger1_i,
    input  logic [VERI_BIT-1:0]    istek1_deger2_i,
    output logic                   yanit1_gecerli_o,
    input  logic                   yanit1_hazir_i,
    output logic [VERI_BIT-1:0]    yanit1_sonuc_o,

    output logic [KONTROL_BIT-1:0] amb_kontrol_o,
    output logic [VERI_BIT-1:0]    amb_deger1_o,
    output logic [VERI_BIT-1:0]    amb_deger2_o,
    input  logic [VERI_BIT-1:0]    amb_sonuc_i
);

    // Round-robin pointer: index of the requester that wins a tie.
    logic                oncelik_r;

    logic [1:0]          w_gecerli;
    logic [1:0]          w_yanit_hazir;
    logic [1:0]          w_uygun;
    logic [1:0]          w_verildi;
    logic [1:0]          w_dolu;
    logic [VERI_BIT-1:0] w_sonuc [2];

    assign w_gecerli     = {istek1_gecerli_i, istek0_gecerli_i};
    assign w_yanit_hazir = {yanit1_hazir_i, yanit0_hazir_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_istek
            logic                yanit_dolu_r;
            logic [VERI_BIT-1:0] yanit_sonuc_r;

            // Slot free now, or being consumed this very cycle (no bubble).
            assign w_uygun[gi] = w_gecerli[gi] && (!yanit_dolu_r || w_yanit_hazir[gi]);
            assign w_dolu[gi]  = yanit_dolu_r;
            assign w_sonuc[gi] = yanit_sonuc_r;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    yanit_dolu_r  <= 1'b0;
                    yanit_sonuc_r <= '0;
                end else if (w_verildi[gi]) begin
                    // A refill wins over a concurrent drain.
                    yanit_dolu_r  <= 1'b1;
                    yanit_sonuc_r <= amb_sonuc_i;
                end else if (w_yanit_hazir[gi]) begin
                    yanit_dolu_r  <= 1'b0;
                end
            end
        end
    endgenerate

    // Grant: a lone eligible requester wins; a tie goes to oncelik_r.
    // Reset suppresses every grant so nothing reaches the ALU.
    always_comb begin
        w_verildi = 2'b00;
        if (!rst_i) begin
            if (&w_uygun) begin
                w_verildi = oncelik_r ? 2'b10 : 2'b01;
            end else begin
                w_verildi = w_uygun;
            end
        end
    end

    always_comb begin
        amb_kontrol_o = '0;
        amb_deger1_o  = '0;
        amb_deger2_o  = '0;
        if (w_verildi[0]) begin
            amb_kontrol_o = istek0_kontrol_i;
            amb_deger1_o  = istek0_deger1_i;
            amb_deger2_o  = istek0_deger2_i;
        end else if (w_verildi[1]) begin
            amb_kontrol_o = istek1_kontrol_i;
            amb_deger1_o  = istek1_deger1_i;
            amb_deger2_o  = istek1_deger2_i;
        end
    end

    // After serving one requester, the other gets the next tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oncelik_r <= 1'b0;
        end else if (w_verildi[0]) begin
            oncelik_r <= 1'b1;
        end else if (w_verildi[1]) begin
            oncelik_r <= 1'b0;
        end
    end

    assign istek0_hazir_o   = w_verildi[0];
    assign istek1_hazir_o   = w_verildi[1];
    assign yanit0_gecerli_o = w_dolu[0];
    assign yanit1_gecerli_o = w_dolu[1];
    assign yanit0_sonuc_o   = w_sonuc[0];
    assign yanit1_sonuc_o   = w_sonuc[1];

endmodule

// File: tb/tb_amb_hakemi.sv
// tb_amb_hakemi
// Bench for amb_hakemi. Provides a small combinational ALU, drives directed
// vectors, checks hand-computed literals, and runs a per-cycle comparison
// against a behavioural model of the arbiter and response slots.
module tb_amb_hakemi;

    localparam int VB = 32;
    localparam int KB = 4;

    // Bench-local opcode values for the stand-in ALU.
    localparam logic [KB-1:0] AMB_TOPLAMA = 4'd0;
    localparam logic [KB-1:0] AMB_CIKARMA = 4'd1;
    localparam logic [KB-1:0] AMB_XOR     = 4'd4;
    localparam logic [KB-1:0] AMB_SLL     = 4'd6;
    localparam logic [KB-1:0] AMB_SRA     = 4'd8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          g0 = 0, g1 = 0, rh0 = 0, rh1 = 0;
    logic [KB-1:0] k0 = '0, k1 = '0;
    logic [VB-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic          h0, h1, v0, v1;
    logic [VB-1:0] s0, s1;
    logic [KB-1:0] amb_k;
    logic [VB-1:0] amb_a, amb_b, amb_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [VB-1:0] alu_ref(input logic [KB-1:0] op,
                                              input logic [VB-1:0] x,
                                              input logic [VB-1:0] y);
        case (op)
            AMB_TOPLAMA: return x + y;
            AMB_CIKARMA: return x - y;
            AMB_XOR:     return x ^ y;
            AMB_SLL:     return x << y[4:0];
            AMB_SRA:     return $unsigned($signed(x) >>> y[4:0]);
            default:     return '0;
        endcase
    endfunction

    assign amb_s = alu_ref(amb_k, amb_a, amb_b);

    amb_hakemi #(.VERI_BIT(VB), .KONTROL_BIT(KB)) dut (
        .clk_i(clk), .rst_i(rst),
        .istek0_gecerli_i(g0), .istek0_hazir_o(h0), .istek0_kontrol_i(k0),
        .istek0_deger1_i(a0), .istek0_deger2_i(b0),
        .yanit0_gecerli_o(v0), .yanit0_hazir_i(rh0), .yanit0_sonuc_o(s0),
        .istek1_gecerli_i(g1), .istek1_hazir_o(h1), .istek1_kontrol_i(k1),
        .istek1_deger1_i(a1), .istek1_deger2_i(b1),
        .yanit1_gecerli_o(v1), .yanit1_hazir_i(rh1), .yanit1_sonuc_o(s1),
        .amb_kontrol_o(amb_k), .amb_deger1_o(amb_a), .amb_deger2_o(amb_b),
        .amb_sonuc_i(amb_s)
    );

    task automatic chk(input string name, input logic [VB-1:0] got, input logic [VB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each response slot is a one-entry buffer: m_full says it holds an
    // unconsumed result, m_val is the last result written into it.
    int            m_pri = 0, n_pri = 0;
    bit            m_full[2], n_full[2];
    logic [VB-1:0] m_val[2], n_val[2];
    bit            m_ok = 0, n_ok = 0;

    always @(negedge clk) begin
        bit el0, el1;
        int gnt;
        logic [KB-1:0] ek;
        logic [VB-1:0] ea, eb;
        el0 = g0 && (!m_full[0] || rh0);
        el1 = g1 && (!m_full[1] || rh1);
        if (rst)             gnt = -1;
        else if (el0 && el1) gnt = m_pri;
        else if (el0)        gnt = 0;
        else if (el1)        gnt = 1;
        else                 gnt = -1;
        if (!m_ok) begin
            el0 = 0; el1 = 0;
            if (!rst) gnt = -2;   // state unknown before the first reset
        end
        if (gnt != -2) begin
            ek = (gnt == 0) ? k0 : (gnt == 1) ? k1 : '0;
            ea = (gnt == 0) ? a0 : (gnt == 1) ? a1 : '0;
            eb = (gnt == 0) ? b0 : (gnt == 1) ? b1 : '0;
            chk("m_hazir0", {31'd0, h0}, {31'd0, gnt == 0});
            chk("m_hazir1", {31'd0, h1}, {31'd0, gnt == 1});
            chk("m_amb_kontrol", {28'd0, amb_k}, {28'd0, ek});
            chk("m_amb_deger1", amb_a, ea);
            chk("m_amb_deger2", amb_b, eb);
        end
        if (m_ok) begin
            chk("m_gecerli0", {31'd0, v0}, {31'd0, m_full[0]});
            chk("m_gecerli1", {31'd0, v1}, {31'd0, m_full[1]});
            chk("m_sonuc0", s0, m_val[0]);
            chk("m_sonuc1", s1, m_val[1]);
        end
        n_pri = m_pri; n_full = m_full; n_val = m_val; n_ok = m_ok;
        if (rst) begin
            n_pri = 0; n_full[0] = 0; n_full[1] = 0;
            n_val[0] = '0; n_val[1] = '0; n_ok = 1;
        end else if (m_ok) begin
            if (rh0) n_full[0] = 0;
            if (rh1) n_full[1] = 0;
            if (gnt == 0) begin
                n_full[0] = 1; n_val[0] = alu_ref(k0, a0, b0); n_pri = 1;
            end else if (gnt == 1) begin
                n_full[1] = 1; n_val[1] = alu_ref(k1, a1, b1); n_pri = 0;
            end
        end
    end

    always @(posedge clk) begin
        m_pri  <= n_pri;
        m_full <= n_full;
        m_val  <= n_val;
        m_ok   <= n_ok;
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic [KB-1:0] k, input logic [VB-1:0] a, input logic [VB-1:0] b);
        g0 = 1; k0 = k; a0 = a; b0 = b;
    endtask

    task automatic req1(input logic [KB-1:0] k, input logic [VB-1:0] a, input logic [VB-1:0] b);
        g1 = 1; k1 = k; a1 = a; b1 = b;
    endtask

    initial begin
        // Reset with a pending request: nothing may be granted.
        req0(AMB_TOPLAMA, 32'd5, 32'd6);
        rh0 = 1; rh1 = 1;
        #2;
        chk("rst_hazir0", {31'd0, h0}, 32'd0);
        chk("rst_amb_deger1", amb_a, 32'd0);
        step(); step();
        chk("rst_gecerli0", {31'd0, v0}, 32'd0);
        chk("rst_sonuc1", s1, 32'd0);

        // Single add on requester 0.
        rst = 0;
        req0(AMB_TOPLAMA, 32'd80, 32'd70);
        #2;
        $display("txn add: hazir0=%0d amb_k=%0d", h0, amb_k);
        chk("add_hazir0", {31'd0, h0}, 32'd1);
        chk("add_amb_deger1", amb_a, 32'd80);
        step();
        g0 = 0;
        chk("add_gecerli0", {31'd0, v0}, 32'd1);
        chk("add_sonuc0", s0, 32'd150);
        step();

        // Tie right after reset: requester 0 first, then requester 1.
        rst = 1; step(); rst = 0;
        req0(AMB_CIKARMA, 32'd80, 32'd70);
        req1(AMB_XOR, 32'hf0f0_f0f0, 32'hff0f_0f0f);
        #2;
        chk("tie_c0_hazir0", {31'd0, h0}, 32'd1);
        chk("tie_c0_hazir1", {31'd0, h1}, 32'd0);
        step();
        #2;
        chk("tie_c1_hazir1", {31'd0, h1}, 32'd1);
        chk("tie_c1_hazir0", {31'd0, h0}, 32'd0);
        chk("tie_sonuc0", s0, 32'd10);
        step();
        chk("tie_sonuc1", s1, 32'h0fff_ffff);
        $display("txn tie: sonuc0=%h sonuc1=%h", s0, s1);

        // Continuous tie: grants alternate starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            #2;
            $display("txn alt %0d: hazir0=%0d hazir1=%0d", i, h0, h1);
            chk("alt_hazir0", {31'd0, h0}, {31'd0, (i % 2) == 0});
            chk("alt_hazir1", {31'd0, h1}, {31'd0, (i % 2) == 1});
            step();
        end

        // Back-pressure on requester 1 must not block requester 0.
        g0 = 0;
        req1(AMB_XOR, 32'hf0f0_f0f0, 32'hff0f_0f0f);
        step();
        rh1 = 0;
        req0(AMB_TOPLAMA, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            a0 = 32'(i);
            #2;
            $display("txn stall %0d: hazir0=%0d hazir1=%0d sonuc1=%h", i, h0, h1, s1);
            chk("stall_hazir1", {31'd0, h1}, 32'd0);
            chk("stall_hazir0", {31'd0, h0}, 32'd1);
            chk("stall_sonuc1", s1, 32'h0fff_ffff);
            step();
        end
        rh1 = 1;
        #2;
        chk("unstall_hazir1", {31'd0, h1}, 32'd1);
        step();

        // Back-to-back shifts on requester 0, no bubble.
        g1 = 0;
        req0(AMB_SLL, 32'hf0f0_f0f0, 32'd4);
        step();
        req0(AMB_SRA, 32'hf0f0_f0f0, 32'd4);
        chk("sll_sonuc0", s0, 32'h0f0f_0f00);
        step();
        g0 = 0;
        chk("sra_gecerli0", {31'd0, v0}, 32'd1);
        chk("sra_sonuc0", s0, 32'hff0f_0f0f);
        $display("txn shift: sonuc0=%h", s0);
        step();

        // Reset the cycle after a grant discards the result.
        req0(AMB_TOPLAMA, 32'd1, 32'd2);
        step();
        rst = 1;
        chk("pre_rst_sonuc0", s0, 32'd3);
        step();
        chk("post_rst_gecerli0", {31'd0, v0}, 32'd0);
        chk("post_rst_sonuc0", s0, 32'd0);
        rst = 0;
        req1(AMB_TOPLAMA, 32'd2, 32'd2);
        #2;
        chk("post_rst_prio0", {31'd0, h0}, 32'd1);
        step();
        g0 = 0; g1 = 0;
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
